ram_bist_ctrl: RTL and testbench

Initiator for the 64x4 single-port RAM block. Drives that RAM's Enable/ReadWrite/Address/DataIn and checks its DataOut.
On start it runs a fixed three-pass march test:
- W0: write P, ascending.
- R0W1: read-expect P then write ~P, ascending.
- R1: read-expect ~P, descending.
It reports pass/fail, first-failure details and an error count. It sits beside the RAM and is controlled by test/top-level logic.

---
 rtl/ram_bist_pkg.sv | 22 ++
 rtl/ram_bist_checker.sv | 82 ++++++++
 rtl/ram_bist_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM march-test BIST controller.
package ram_bist_pkg;

    // Default geometry of the RAM under test and the error counter.
    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 7;

    // Encoding of the RAM ReadWrite pin.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // March-test phases, in the order they are visited.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        W0    = 3'd1,
        R0W1  = 3'd2,
        R1    = 3'd3,
        DRAIN = 3'd4
    } bist_state_e;

endpackage : ram_bist_pkg

// File: rtl/ram_bist_checker.sv
// Compare stage of the BIST: counts mismatches (saturating) and captures the
// first failing address/expected/actual words of a run.
module ram_bist_checker
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              cmp_valid,
    input  logic [DATA_W-1:0] cmp_exp,
    input  logic [ADDR_W-1:0] cmp_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act,
    output logic              clean
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // True when the word read back differs from the expected background.
    function automatic logic word_mismatch(input logic [DATA_W-1:0] act,
                                           input logic [DATA_W-1:0] exp);
        return (act != exp);
    endfunction

    logic [CNT_W-1:0]  err_cnt_r;
    logic [ADDR_W-1:0] fail_addr_r;
    logic [DATA_W-1:0] fail_exp_r;
    logic [DATA_W-1:0] fail_act_r;
    logic              mismatch_s;

    // A compare only happens in the slot right after a read was issued.
    always_comb begin
        mismatch_s = 1'b0;
        if (cmp_valid) begin
            mismatch_s = word_mismatch(ram_dout, cmp_exp);
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Error counter and first-failure capture; the count never returns to
    // zero within a run, so zero doubles as "no failure captured yet".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r   <= CNT_ZERO;
            fail_addr_r <= {ADDR_W{1'b0}};
            fail_exp_r  <= {DATA_W{1'b0}};
            fail_act_r  <= {DATA_W{1'b0}};
        end else if (clr) begin
            err_cnt_r   <= CNT_ZERO;
            fail_addr_r <= {ADDR_W{1'b0}};
            fail_exp_r  <= {DATA_W{1'b0}};
            fail_act_r  <= {DATA_W{1'b0}};
        end else if (mismatch_s) begin
            if (err_cnt_r != CNT_MAX) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end
            if (err_cnt_r == CNT_ZERO) begin
                fail_addr_r <= cmp_addr;
                fail_exp_r  <= cmp_exp;
                fail_act_r  <= ram_dout;
            end
        end
    end

    assign err_count = err_cnt_r;
    assign fail_addr = fail_addr_r;
    assign fail_exp  = fail_exp_r;
    assign fail_act  = fail_act_r;
    // Run is still clean including any compare landing this cycle.
    assign clean     = (err_cnt_r == CNT_ZERO) && !mismatch_s;

endmodule : ram_bist_checker

// File: rtl/ram_bist_ctrl.sv
// March-test BIST initiator for a single-port RAM: W0 (up), R0W1 (up),
// R1 (down), then a drain cycle for the last read's compare.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] pattern,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // Current state and the RAM access presented on the outputs this cycle.
    bist_state_e       state_r,  state_s;
    logic [ADDR_W-1:0] addr_r,   addr_s;
    logic              phase_r,  phase_s;   // R0W1: 0 = read slot, 1 = write slot
    logic [DATA_W-1:0] p_r,      p_s;
    logic              ram_en_r, ram_en_s;
    logic              ram_rw_r, ram_rw_s;
    logic [DATA_W-1:0] ram_din_r, ram_din_s;
    logic              busy_r,   busy_s;
    logic              done_r,   done_s;
    logic              pass_r,   pass_s;
    logic              clr_s;

    // Compare pipeline: describes the read issued in the previous cycle.
    logic              cmp_valid_r;
    logic [DATA_W-1:0] cmp_exp_r;
    logic [ADDR_W-1:0] cmp_addr_r;
    logic              clean_s;

    // Next-state, next-access and status decode.
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        phase_s   = phase_r;
        p_s       = p_r;
        ram_en_s  = 1'b0;
        ram_rw_s  = RW_READ;
        ram_din_s = DATA_ZERO;
        busy_s    = busy_r;
        done_s    = 1'b0;
        pass_s    = pass_r;
        clr_s     = 1'b0;

        if (abort && (state_r != IDLE)) begin
            state_s = IDLE;
            addr_s  = ADDR_ZERO;
            phase_s = 1'b0;
            busy_s  = 1'b0;
            pass_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && !abort) begin
                        state_s   = W0;
                        p_s       = pattern;
                        addr_s    = ADDR_ZERO;
                        phase_s   = 1'b0;
                        ram_en_s  = 1'b1;
                        ram_rw_s  = RW_WRITE;
                        ram_din_s = pattern;
                        busy_s    = 1'b1;
                        pass_s    = 1'b0;
                        clr_s     = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                W0: begin
                    if (addr_r == ADDR_MAX) begin
                        state_s  = R0W1;
                        addr_s   = ADDR_ZERO;
                        phase_s  = 1'b0;
                        ram_en_s = 1'b1;
                        ram_rw_s = RW_READ;
                    end else begin
                        addr_s    = addr_r + ADDR_ONE;
                        ram_en_s  = 1'b1;
                        ram_rw_s  = RW_WRITE;
                        ram_din_s = p_r;
                    end
                end
                R0W1: begin
                    if (!phase_r) begin
                        phase_s   = 1'b1;
                        ram_en_s  = 1'b1;
                        ram_rw_s  = RW_WRITE;
                        ram_din_s = ~p_r;
                    end else if (addr_r == ADDR_MAX) begin
                        state_s  = R1;
                        addr_s   = ADDR_MAX;
                        phase_s  = 1'b0;
                        ram_en_s = 1'b1;
                        ram_rw_s = RW_READ;
                    end else begin
                        phase_s  = 1'b0;
                        addr_s   = addr_r + ADDR_ONE;
                        ram_en_s = 1'b1;
                        ram_rw_s = RW_READ;
                    end
                end
                R1: begin
                    if (addr_r == ADDR_ZERO) begin
                        state_s = DRAIN;
                    end else begin
                        addr_s   = addr_r - ADDR_ONE;
                        ram_en_s = 1'b1;
                        ram_rw_s = RW_READ;
                    end
                end
                DRAIN: begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = clean_s;
                end
                default: begin
                    state_s = IDLE;
                    addr_s  = ADDR_ZERO;
                    phase_s = 1'b0;
                    busy_s  = 1'b0;
                    pass_s  = 1'b0;
                end
            endcase
        end
    end

    // State, address generator and registered RAM/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            addr_r    <= ADDR_ZERO;
            phase_r   <= 1'b0;
            p_r       <= DATA_ZERO;
            ram_en_r  <= 1'b0;
            ram_rw_r  <= RW_READ;
            ram_din_r <= DATA_ZERO;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            addr_r    <= addr_s;
            phase_r   <= phase_s;
            p_r       <= p_s;
            ram_en_r  <= ram_en_s;
            ram_rw_r  <= ram_rw_s;
            ram_din_r <= ram_din_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            pass_r    <= pass_s;
        end
    end

    // Delay each issued read by one cycle so its compare lines up with
    // ram_dout; an abort cancels the pending compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_valid_r <= 1'b0;
            cmp_exp_r   <= DATA_ZERO;
            cmp_addr_r  <= ADDR_ZERO;
        end else begin
            cmp_valid_r <= ram_en_r && (ram_rw_r == RW_READ) && !abort;
            cmp_exp_r   <= (state_r == R1) ? ~p_r : p_r;
            cmp_addr_r  <= addr_r;
        end
    end

    ram_bist_checker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_s),
        .cmp_valid (cmp_valid_r),
        .cmp_exp   (cmp_exp_r),
        .cmp_addr  (cmp_addr_r),
        .ram_dout  (ram_dout),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_act  (fail_act),
        .clean     (clean_s)
    );

    assign ram_en   = ram_en_r;
    assign ram_rw   = ram_rw_r;
    assign ram_addr = addr_r;
    assign ram_din  = ram_din_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;

endmodule : ram_bist_ctrl

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl: behavioural 64x4 RAM with
// injectable stuck-at faults, and a reference march model built from arrays.
module tb_ram_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [3:0] pattern;
    logic       ram_en, ram_rw;
    logic [5:0] ram_addr;
    logic [3:0] ram_din, ram_dout;
    logic       busy, done, pass;
    logic [5:0] fail_addr;
    logic [3:0] fail_exp, fail_act;
    logic [6:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] mem     [64];
    logic [3:0] ref_mem [64];
    logic [3:0] sa1     [64];
    logic [3:0] sa0     [64];
    bit         zero_mode;

    always #5 clk = ~clk;

    ram_bist_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pattern(pattern),
        .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act),
        .err_count(err_count)
    );

    // Faulty-cell read behaviour shared by the RAM model and the reference.
    function automatic logic [3:0] fault_read(input logic [3:0] w, input int a);
        if (zero_mode) return 4'b0000;
        return (w | sa1[a]) & ~sa0[a];
    endfunction

    // Behavioural synchronous single-port RAM, read data valid next cycle.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_rw) ram_dout <= fault_read(mem[ram_addr], int'(ram_addr));
            else        mem[ram_addr] <= ram_din;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 64; i++) begin
            sa1[i] = 4'b0000;
            sa0[i] = 4'b0000;
        end
        zero_mode = 1'b0;
    endtask

    // Expected RAM access in busy cycle k (1-based) of a run with pattern p.
    function automatic bit sched_ok(input int k, input logic [3:0] p);
        logic       e_en, e_rw;
        int         e_a, j;
        logic [3:0] e_d;
        logic [5:0] e_a6;
        e_en = 1'b1; e_rw = 1'b1; e_a = 0; e_d = 4'b0000;
        if (k <= 64) begin
            e_rw = 1'b0; e_a = k - 1; e_d = p;
        end else if (k <= 192) begin
            j = k - 65; e_a = j / 2;
            e_rw = (j % 2 == 0); e_d = ~p;
        end else if (k <= 256) begin
            e_a = 63 - (k - 193);
        end else begin
            e_en = 1'b0;
        end
        e_a6 = e_a[5:0];
        if (k > 257) return 1'b0;
        if (!e_en) return (ram_en == 1'b0);
        return ram_en && (ram_rw == e_rw) && (ram_addr == e_a6) && (e_rw || ram_din == e_d);
    endfunction

    // Reference march test: W0 up, R0W1 up, R1 down over the faulty array.
    task automatic ref_march(input logic [3:0] p, output int e_err, output logic [5:0] e_fa,
                             output logic [3:0] e_fe, output logic [3:0] e_fact);
        int raw;
        logic [3:0] r;
        raw = 0; e_fa = 6'd0; e_fe = 4'd0; e_fact = 4'd0;
        for (int a = 0; a < 64; a++) ref_mem[a] = p;
        for (int a = 0; a < 64; a++) begin
            r = fault_read(ref_mem[a], a);
            if (r != p) begin
                if (raw == 0) begin e_fa = 6'(a); e_fe = p; e_fact = r; end
                raw++;
            end
            ref_mem[a] = ~p;
        end
        for (int a = 63; a >= 0; a--) begin
            r = fault_read(ref_mem[a], a);
            if (r != ~p) begin
                if (raw == 0) begin e_fa = 6'(a); e_fe = ~p; e_fact = r; end
                raw++;
            end
        end
        e_err = (raw > 127) ? 127 : raw;
    endtask

    // One complete run from IDLE, checked against the reference model.
    task automatic run_full(input logic [3:0] p, input string tag, output bit exp_pass);
        int e_err, k, bad, early, memdiff;
        logic [5:0] e_fa;
        logic [3:0] e_fe, e_fact;
        ref_march(p, e_err, e_fa, e_fe, e_fact);
        exp_pass = (e_err == 0);
        pattern = p; start = 1'b1;
        tick();
        start = 1'b0; pattern = 4'($urandom_range(0, 15));
        k = 1; bad = 0; early = 0;
        while (busy === 1'b1 && k <= 300) begin
            if (!sched_ok(k, p)) bad++;
            if (done) early++;
            tick();
            k++;
        end
        check_eq({tag, "_busy_len"}, k - 1, 257);
        check_eq({tag, "_sched"}, bad, 0);
        check_eq({tag, "_early_done"}, early, 0);
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_ram_en_idle"}, ram_en, 0);
        check_eq({tag, "_pass"}, pass, exp_pass);
        check_eq({tag, "_err_count"}, err_count, e_err);
        check_eq({tag, "_fail_addr"}, fail_addr, e_fa);
        check_eq({tag, "_fail_exp"}, fail_exp, e_fe);
        check_eq({tag, "_fail_act"}, fail_act, e_fact);
        memdiff = 0;
        for (int a = 0; a < 64; a++) if (mem[a] !== ref_mem[a]) memdiff++;
        check_eq({tag, "_mem"}, memdiff, 0);
        tick();
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_pass_hold"}, pass, exp_pass);
    endtask

    initial begin
        bit ep;
        int k, seen, bad0101, a, nf;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pattern = 4'b0000;
        clear_faults();
        repeat (3) tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ram_en", ram_en, 0);
        check_eq("rst_ram_rw", ram_rw, 1);
        check_eq("rst_outs", {done, pass, ram_addr, ram_din, err_count, fail_addr, fail_exp, fail_act}, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // start together with abort in IDLE: abort wins
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        tick();
        check_eq("start_abort_idle", busy, 0);

        // fault-free, pattern 1010
        run_full(4'b1010, "clean", ep);
        bad0101 = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 4'b0101) bad0101++;
        check_eq("clean_final_0101", bad0101, 0);
        check_eq("clean_pass_const", pass, 1);

        // bit0 of address 5 stuck-at-1
        clear_faults(); sa1[5] = 4'b0001;
        run_full(4'b0000, "sa1_a5", ep);
        check_eq("sa1_a5_const", {err_count, fail_addr, fail_exp, fail_act, pass},
                 {7'd1, 6'd5, 4'b0000, 4'b0001, 1'b0});

        // bit3 of address 63 stuck-at-0
        clear_faults(); sa0[63] = 4'b1000;
        run_full(4'b0000, "sa0_a63", ep);
        check_eq("sa0_a63_const", {err_count, fail_addr, fail_exp, fail_act},
                 {7'd1, 6'd63, 4'b1111, 4'b0111});

        // RAM returns zero always: 128 raw mismatches saturate at 127
        clear_faults(); zero_mode = 1'b1;
        run_full(4'b0101, "zero", ep);
        check_eq("zero_const", {err_count, fail_addr, fail_exp, fail_act},
                 {7'd127, 6'd0, 4'b0101, 4'b0000});

        // abort 100 cycles into a run that already logged a failure
        clear_faults(); sa1[5] = 4'b0001;
        pattern = 4'b0000; start = 1'b1; tick(); start = 1'b0;
        k = 1;
        while (k < 100 && busy) begin tick(); k++; end
        abort = 1'b1; tick(); abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_ram_en", ram_en, 0);
        check_eq("abort_done_pass", {done, pass}, 0);
        check_eq("abort_partial_err", err_count, 1);
        check_eq("abort_partial_addr", fail_addr, 5);
        seen = 0;
        repeat (300) begin
            if (done || busy || ram_en) seen++;
            tick();
        end
        check_eq("abort_quiet", seen, 0);
        run_full(4'b0000, "abort_rerun", ep);

        // randomized runs with random stuck-at cells and idle-time aborts
        repeat (6) begin
            clear_faults();
            nf = $urandom_range(0, 3);
            repeat (nf) begin
                a = $urandom_range(0, 63);
                if ($urandom_range(0, 1) == 1) sa1[a] = sa1[a] | 4'(1 << $urandom_range(0, 3));
                else                           sa0[a] = sa0[a] | 4'(1 << $urandom_range(0, 3));
            end
            run_full(4'($urandom_range(0, 15)), "rnd", ep);
            repeat ($urandom_range(1, 5)) begin
                abort = 1'($urandom_range(0, 1));
                tick();
            end
            abort = 1'b0;
            check_eq("rnd_idle_abort_pass", pass, ep);
            check_eq("rnd_idle_abort_busy", busy, 0);
        end

        // start re-pulsed mid-run is ignored; reset mid-run clears everything
        clear_faults(); sa1[3] = 4'b0010;
        pattern = 4'b0110; start = 1'b1; tick(); start = 1'b0;
        k = 1; seen = 0;
        while (k < 150) begin
            if (k == 50) start = 1'b1;
            if (!sched_ok(k, 4'b0110)) seen++;
            tick();
            start = 1'b0;
            k++;
        end
        check_eq("repulse_sched", seen, 0);
        check_eq("repulse_c150", sched_ok(150, 4'b0110), 1);
        check_eq("repulse_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_ram", {ram_en, ram_rw}, 2'b01);
        check_eq("midrst_outs", {busy, done, pass, ram_addr, ram_din, err_count, fail_addr, fail_exp, fail_act}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_faults();
        run_full(4'b1100, "post_rst", ep);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ram_bist_ctrl
